dds_tune_wb_slave: RTL

Wishbone responder that receives DDS tuning commands from the host and buffers them in a FIFO. It releases one command per sample strobe to the D3S DDS datapath. It sits between the host Wishbone crossbar and the DDS phase accumulator on the `clk_sys` domain. Each entry carries a tune value and an optional phase-accumulator load request, with the 48-bit load value latched from registers.

---
 rtl/dds_tune_pkg.sv | 26 ++
 rtl/dds_tune_wb_slave_if.sv | 22 ++
 rtl/dds_tune_fifo.sv | 66 ++++++
 rtl/dds_tune_wb_slave.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dds_tune_pkg.sv
// Shared definitions for the DDS tuning Wishbone slave: register map,
// CSR bit positions and the tune FIFO entry format.
package dds_tune_pkg;

  localparam logic [2:0] ADR_CSR       = 3'd0;
  localparam logic [2:0] ADR_TUNE_VAL  = 3'd1;
  localparam logic [2:0] ADR_ACC_HI    = 3'd2;
  localparam logic [2:0] ADR_ACC_LO    = 3'd3;
  localparam logic [2:0] ADR_WATERMARK = 3'd4;

  localparam int CSR_ENABLE    = 0;
  localparam int CSR_CLEAR     = 1;
  localparam int CSR_FILL_LSB  = 8;
  localparam int CSR_FULL      = 16;
  localparam int CSR_EMPTY     = 17;
  localparam int CSR_UNDERFLOW = 18;
  localparam int CSR_OVERFLOW  = 19;

  localparam int LOAD_ACC = 31;

  typedef struct packed {
    logic        load_acc;
    logic [23:0] tune;
  } t_tune_entry;

endpackage

// File: rtl/dds_tune_wb_slave_if.sv
// Pipelined Wishbone bus bundle between the host crossbar and the tune slave.
interface dds_tune_wb_slave_if;
  logic [2:0]  adr;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        stall;

  modport master (
    output adr, dat_wr, sel, cyc, stb, we,
    input  dat_rd, ack, stall
  );

  modport slave (
    input  adr, dat_wr, sel, cyc, stb, we,
    output dat_rd, ack, stall
  );
endinterface

// File: rtl/dds_tune_fifo.sv
// Synchronous FIFO with clear and fill count; read data is registered on pop.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module dds_tune_fifo
  import dds_tune_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = t_tune_entry,
  localparam int AW    = $clog2(DEPTH),
  localparam int FW    = AW + 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic [FW-1:0] fill,
  output logic          full,
  output logic          empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [FW-1:0] fill_reg;
  T              pop_data_reg;

  always_ff @(posedge clk) begin
    if (push && !clear && !srst) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      pop_data_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  assign pop_data = pop_data_reg;
  assign fill     = fill_reg;
  assign full     = (fill_reg == FW'(DEPTH));
  assign empty    = (fill_reg == '0);

endmodule

// File: rtl/dds_tune_wb_slave.sv
// Wishbone responder buffering DDS tune commands, releasing one per sample strobe.
// Optional WATERMARK register enabled by defining DDS_TUNE_FIFO_STATS_EN.
module dds_tune_wb_slave
  import dds_tune_pkg::*;
#(
  parameter int g_fifo_depth = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  dds_tune_wb_slave_if.slave   wb,
  input  logic                 sample_p_i,
  output logic [23:0]          tune_o,
  output logic                 tune_valid_o,
  output logic [47:0]          acc_load_o,
  output logic                 acc_load_p_o
);

  localparam int FW = $clog2(g_fifo_depth) + 1;

  logic          enable_reg;
  logic          underflow_reg;
  logic          overflow_reg;
  logic [15:0]   acc_hi_reg;
  logic [31:0]   acc_lo_reg;
  logic [47:0]   acc_load_reg;
  logic          tune_valid_reg;
  logic          ack_reg;
  logic [31:0]   dat_rd_reg;

  logic          req, csr_wr, tune_wr, clear;
  logic          pop_req, do_pop, do_push, underflow_evt, overflow_evt;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_fill;
  logic [8:0]    fill_ext;
  logic [8:0]    watermark;
  logic [31:0]   rd_data;
  t_tune_entry   push_entry, pop_entry;

  assign req     = wb.cyc & wb.stb;
  assign csr_wr  = req & wb.we & (wb.adr == ADR_CSR);
  assign tune_wr = req & wb.we & (wb.adr == ADR_TUNE_VAL);
  assign clear   = csr_wr & wb.dat_wr[CSR_CLEAR];

  // Popping frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_req       = sample_p_i & enable_reg;
  assign do_pop        = pop_req & ~fifo_empty & ~clear;
  assign do_push       = tune_wr & (~fifo_full | do_pop) & ~clear;
  assign underflow_evt = pop_req & fifo_empty & ~clear;
  assign overflow_evt  = tune_wr & fifo_full & ~do_pop & ~clear;

  assign push_entry = '{load_acc: wb.dat_wr[LOAD_ACC], tune: wb.dat_wr[23:0]};
  assign fill_ext   = 9'(fifo_fill);

  dds_tune_fifo #(
    .DEPTH (g_fifo_depth),
    .T     (t_tune_entry)
  ) u_fifo (
    .clk       (clk_sys_i),
    .srst      (rst_sys_i),
    .clear     (clear),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .pop_data  (pop_entry),
    .fill      (fifo_fill),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef DDS_TUNE_FIFO_STATS_EN
  logic [8:0] watermark_reg;

  // Folding in the live fill keeps reads current without a one-cycle lag.
  assign watermark = (fill_ext > watermark_reg) ? fill_ext : watermark_reg;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i || clear) begin
      watermark_reg <= '0;
    end else begin
      watermark_reg <= watermark;
    end
  end
`else
  assign watermark = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (wb.adr)
      ADR_CSR: begin
        rd_data[CSR_ENABLE]                 = enable_reg;
        rd_data[CSR_FILL_LSB +: 8]          = fill_ext[7:0];
        rd_data[CSR_FULL]                   = fifo_full;
        rd_data[CSR_EMPTY]                  = fifo_empty;
        rd_data[CSR_UNDERFLOW]              = underflow_reg;
        rd_data[CSR_OVERFLOW]               = overflow_reg;
      end
      ADR_ACC_HI:    rd_data[15:0] = acc_hi_reg;
      ADR_ACC_LO:    rd_data       = acc_lo_reg;
      ADR_WATERMARK: rd_data[8:0]  = watermark;
      default:       rd_data       = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      enable_reg     <= 1'b0;
      underflow_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      acc_hi_reg     <= '0;
      acc_lo_reg     <= '0;
      acc_load_reg   <= '0;
      tune_valid_reg <= 1'b0;
      ack_reg        <= 1'b0;
      dat_rd_reg     <= '0;
    end else begin
      ack_reg        <= req;
      tune_valid_reg <= do_pop;
      if (req) begin
        dat_rd_reg <= rd_data;
      end
      if (csr_wr) begin
        enable_reg <= wb.dat_wr[CSR_ENABLE];
      end
      if (req && wb.we && wb.adr == ADR_ACC_HI) begin
        acc_hi_reg <= wb.dat_wr[15:0];
      end
      if (req && wb.we && wb.adr == ADR_ACC_LO) begin
        acc_lo_reg <= wb.dat_wr;
      end
      if (do_pop) begin
        acc_load_reg <= {acc_hi_reg, acc_lo_reg};
      end
      // A new event outranks a simultaneous write-1-clear.
      if (underflow_evt) begin
        underflow_reg <= 1'b1;
      end else if (csr_wr && wb.dat_wr[CSR_UNDERFLOW]) begin
        underflow_reg <= 1'b0;
      end
      if (overflow_evt) begin
        overflow_reg <= 1'b1;
      end else if (csr_wr && wb.dat_wr[CSR_OVERFLOW]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign wb.ack       = ack_reg;
  assign wb.dat_rd    = dat_rd_reg;
  assign wb.stall     = 1'b0;
  assign tune_o       = pop_entry.tune;
  assign tune_valid_o = tune_valid_reg;
  assign acc_load_o   = acc_load_reg;
  assign acc_load_p_o = tune_valid_reg & pop_entry.load_acc;

  logic unused_bits;
  assign unused_bits = ^{wb.sel, fill_ext[8]};

endmodule
